// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-ported 16-bit data memory between
// the fetch port (I) and the load/store port (D), with fixed access latency.
module mem_port_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_rdata,
    output logic        i_done,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        lastWinner_q, lastWinner_d;
    logic        winner_q, winner_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] iRdata_q, iRdata_d;
    logic [15:0] dRdata_q, dRdata_d;
    logic        grantD;
    logic        inAccess;

    // Winner bit: 0 = fetch port, 1 = data port. On a tie, the port that did not win last time is granted.
    assign grantD = d_req && (!i_req || !lastWinner_q);

    always_comb begin
        state_d      = state_q;
        lastWinner_d = lastWinner_q;
        winner_d     = winner_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        iRdata_d     = iRdata_q;
        dRdata_d     = dRdata_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    winner_d = grantD;
                    if (i_req && d_req) begin
                        lastWinner_d = grantD;
                    end
                    addr_d  = grantD ? d_addr : i_addr;
                    wr_d    = grantD && d_wr;
                    wdata_d = grantD ? d_wdata : 16'h0000;
                    if (addr_d[0]) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        if (grantD) begin
                            dRdata_d = 16'h0000;
                        end else begin
                            iRdata_d = 16'h0000;
                        end
                    end else begin
                        state_d = ACCESS;
                        err_d   = 1'b0;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (winner_q) begin
                        dRdata_d = wr_q ? 16'h0000 : mem_rdata;
                    end else begin
                        iRdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset abandons any access in flight; the bus outputs decode from state and drop at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lastWinner_q <= 1'b0;
            winner_q     <= 1'b0;
            addr_q       <= 16'h0000;
            wr_q         <= 1'b0;
            wdata_q      <= 16'h0000;
            err_q        <= 1'b0;
            cnt_q        <= 4'd0;
            iRdata_q     <= 16'h0000;
            dRdata_q     <= 16'h0000;
        end else begin
            state_q      <= state_d;
            lastWinner_q <= lastWinner_d;
            winner_q     <= winner_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            iRdata_q     <= iRdata_d;
            dRdata_q     <= dRdata_d;
        end
    end

    // The write strobe is confined to the final access cycle so a store produces exactly one write edge.
    always_comb begin
        inAccess  = (state_q == ACCESS);
        mem_en    = inAccess;
        mem_wr    = inAccess && wr_q && (cnt_q == 4'd0);
        mem_addr  = inAccess ? addr_q : 16'h0000;
        mem_wdata = inAccess ? wdata_q : 16'h0000;
        i_done    = (state_q == RESP) && !winner_q;
        d_done    = (state_q == RESP) && winner_q;
        i_err     = i_done && err_q;
        d_err     = d_done && err_q;
        busy      = (state_q == ACCESS) || (state_q == RESP);
        i_rdata   = iRdata_q;
        d_rdata   = dRdata_q;
    end

endmodule
